// File: rtl/vga_rx_pkg.sv
// Shared types, counter width and 640x480@60 reference timing for the VGA capture receiver.
package vga_rx_pkg;

  typedef enum logic [1:0] {SEARCH, MEASURE, CONFIRM, LOCKED} state_t;

  localparam int CNT_W = 11;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Sync-input conditioner: register chain on pix_en, polarity normalised to
// active-high, and a one-tick pulse on each assert edge.
module vga_sync_edge
  import vga_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit ACT_LOW     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pix_en,
  input  logic sync_raw,
  output logic assert_edge
);

  logic [SYNC_STAGES-1:0] chain_reg;
  logic                   level;
  logic                   level_prev_reg;

  // Chain resets to the inactive level so reset release never fakes an edge.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)
            chain_reg[gi] <= ACT_LOW;
          else if (pix_en)
            chain_reg[gi] <= sync_raw;
        end
      end else begin : g_next
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)
            chain_reg[gi] <= ACT_LOW;
          else if (pix_en)
            chain_reg[gi] <= chain_reg[gi-1];
        end
      end
    end
  endgenerate

  assign level = chain_reg[SYNC_STAGES-1] ^ ACT_LOW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      level_prev_reg <= 1'b0;
    else if (pix_en)
      level_prev_reg <= level;
  end

  assign assert_edge = pix_en & level & ~level_prev_reg;

endmodule

// File: rtl/vga_capture_rx.sv
// VGA link receiver: recovers pixel timing from HS/VS, measures line/frame
// lengths, locks after two identical frames and streams active pixels.
module vga_capture_rx
  import vga_rx_pkg::*;
#(
  parameter int VGA_BITS    = 8,
  parameter int SYNC_STAGES = 2,
  parameter bit HS_ACT_LOW  = 1'b1,
  parameter bit VS_ACT_LOW  = 1'b1,
  parameter int H_START     = H_SYNC + H_BACK,
  parameter int H_ACTIVE    = H_VISIBLE,
  parameter int V_START     = V_SYNC + V_BACK,
  parameter int V_ACTIVE    = V_VISIBLE,
  parameter int TIMEOUT     = 2047
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pix_en,
  input  logic                hs_in,
  input  logic                vs_in,
  input  logic [VGA_BITS-1:0] r_in,
  input  logic [VGA_BITS-1:0] g_in,
  input  logic [VGA_BITS-1:0] b_in,
  output logic                pix_valid,
  output logic [9:0]          pix_x,
  output logic [9:0]          pix_y,
  output logic [VGA_BITS-1:0] pix_r,
  output logic [VGA_BITS-1:0] pix_g,
  output logic [VGA_BITS-1:0] pix_b,
  output logic                frame_start,
  output logic                locked,
  output logic [CNT_W-1:0]    h_total,
  output logic [CNT_W-1:0]    v_total
);

  localparam logic [CNT_W-1:0] H_LO = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] H_HI = CNT_W'(H_START + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_LO = CNT_W'(V_START);
  localparam logic [CNT_W-1:0] V_HI = CNT_W'(V_START + V_ACTIVE);
  localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT);
  localparam int               RGB_W = 3 * VGA_BITS;

  logic hs_edge, vs_edge;

  vga_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .ACT_LOW(HS_ACT_LOW)) u_hs_edge (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .sync_raw(hs_in), .assert_edge(hs_edge)
  );

  vga_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .ACT_LOW(VS_ACT_LOW)) u_vs_edge (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .sync_raw(vs_in), .assert_edge(vs_edge)
  );

  // One extra stage beyond the sync depth lines colour up with the counters.
  logic [SYNC_STAGES:0][RGB_W-1:0] rgb_pipe_reg;

  genvar gi;
  generate
    for (gi = 0; gi <= SYNC_STAGES; gi++) begin : g_rgb
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)
            rgb_pipe_reg[gi] <= '0;
          else if (pix_en)
            rgb_pipe_reg[gi] <= {r_in, g_in, b_in};
        end
      end else begin : g_next
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)
            rgb_pipe_reg[gi] <= '0;
          else if (pix_en)
            rgb_pipe_reg[gi] <= rgb_pipe_reg[gi-1];
        end
      end
    end
  endgenerate

  logic [CNT_W-1:0] hcnt_reg, hcnt_next;
  logic [CNT_W-1:0] vcnt_reg, vcnt_next;
  logic [CNT_W-1:0] first_len_reg;
  logic             first_vld_reg;
  logic             line_err_reg;
  logic [CNT_W-1:0] h_total_reg, v_total_reg;
  state_t           state_reg, state_next;

  logic [CNT_W-1:0] line_len, frame_lines;
  logic             line_bad, frame_err, frame_ok, same_totals, timeout;

  always_comb begin
    hcnt_next = hcnt_reg;
    vcnt_next = vcnt_reg;
    if (pix_en) begin
      hcnt_next = hs_edge ? '0 : sat_inc(hcnt_reg);
      if (vs_edge)
        vcnt_next = '0;
      else if (hs_edge)
        vcnt_next = sat_inc(vcnt_reg);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_reg <= '0;
      vcnt_reg <= '0;
    end else begin
      hcnt_reg <= hcnt_next;
      vcnt_reg <= vcnt_next;
    end
  end

  // A line ending on the VS edge still belongs to the frame being closed.
  assign line_len    = hcnt_reg + 1'b1;
  assign line_bad    = hs_edge & first_vld_reg & (line_len != first_len_reg);
  assign frame_err   = line_err_reg | line_bad;
  assign frame_lines = vcnt_reg + {{(CNT_W-1){1'b0}}, hs_edge};
  assign frame_ok    = ~frame_err & first_vld_reg & (first_len_reg > H_HI) & (frame_lines > V_HI);
  assign same_totals = (first_len_reg == h_total_reg) & (frame_lines == v_total_reg);
  assign timeout     = pix_en & (hcnt_reg >= TMO) & ~hs_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_len_reg <= '0;
      first_vld_reg <= 1'b0;
      line_err_reg  <= 1'b0;
    end else if (vs_edge) begin
      first_vld_reg <= 1'b0;
      line_err_reg  <= 1'b0;
    end else if (hs_edge) begin
      if (!first_vld_reg) begin
        first_len_reg <= line_len;
        first_vld_reg <= 1'b1;
      end else if (line_bad) begin
        line_err_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= SEARCH;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (timeout) begin
      state_next = SEARCH;
    end else begin
      unique case (state_reg)
        SEARCH:  if (vs_edge) state_next = MEASURE;
        MEASURE: if (vs_edge && frame_ok) state_next = CONFIRM;
        CONFIRM: if (vs_edge) state_next = (frame_ok && same_totals) ? LOCKED : MEASURE;
        LOCKED: begin
          if (line_bad || (vs_edge && !(frame_ok && same_totals)))
            state_next = MEASURE;
        end
        default: state_next = SEARCH;
      endcase
    end
  end

  always_comb begin
    locked = (state_reg == LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_total_reg <= '0;
      v_total_reg <= '0;
    end else if (!timeout && state_reg == MEASURE && vs_edge) begin
      h_total_reg <= first_len_reg;
      v_total_reg <= frame_lines;
    end
  end

  logic                in_window, fire;
  logic                pix_valid_reg, frame_start_reg;
  logic [9:0]          pix_x_reg, pix_y_reg;
  logic [RGB_W-1:0]    pix_rgb_reg;

  assign in_window = (hcnt_reg >= H_LO) && (hcnt_reg < H_HI) &&
                     (vcnt_reg >= V_LO) && (vcnt_reg < V_HI);
  assign fire      = pix_en & in_window & locked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid_reg   <= 1'b0;
      frame_start_reg <= 1'b0;
      pix_x_reg       <= '0;
      pix_y_reg       <= '0;
      pix_rgb_reg     <= '0;
    end else begin
      pix_valid_reg   <= fire;
      frame_start_reg <= fire && (hcnt_reg == H_LO) && (vcnt_reg == V_LO);
      if (fire) begin
        pix_x_reg   <= 10'(hcnt_reg - H_LO);
        pix_y_reg   <= 10'(vcnt_reg - V_LO);
        pix_rgb_reg <= rgb_pipe_reg[SYNC_STAGES];
      end
    end
  end

  assign pix_valid             = pix_valid_reg;
  assign frame_start           = frame_start_reg;
  assign pix_x                 = pix_x_reg;
  assign pix_y                 = pix_y_reg;
  assign {pix_r, pix_g, pix_b} = pix_rgb_reg;
  assign h_total               = h_total_reg;
  assign v_total               = v_total_reg;

endmodule

// File: tb/tb_vga_capture_rx.sv
// Scoreboard bench for vga_capture_rx using a reduced 32x14 raster so whole
// lock/unlock sequences fit in a short run.
module tb_vga_capture_rx;

  localparam int HT  = 32;
  localparam int VT  = 14;
  localparam int HSW = 4;
  localparam int VSW = 2;
  localparam int HS  = 8;
  localparam int HA  = 20;
  localparam int VS  = 3;
  localparam int VA  = 8;
  localparam int S   = 2;

  logic        clk = 1'b0;
  logic        rst_n, pix_en, hs_in, vs_in;
  logic [7:0]  r_in, g_in, b_in;
  logic        pix_valid, frame_start, locked;
  logic [9:0]  pix_x, pix_y;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic [10:0] h_total, v_total;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       fs;
  } pix_t;

  pix_t exp_q[$];
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   pix_cnt = 0;

  always #5 clk = ~clk;

  vga_capture_rx #(
    .VGA_BITS(8), .SYNC_STAGES(S), .HS_ACT_LOW(1'b1), .VS_ACT_LOW(1'b1),
    .H_START(HS), .H_ACTIVE(HA), .V_START(VS), .V_ACTIVE(VA), .TIMEOUT(2047)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hs_in(hs_in), .vs_in(vs_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .frame_start(frame_start), .locked(locked),
    .h_total(h_total), .v_total(v_total)
  );

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end else begin
      $display("ok   %s: %0d", name, got);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".locked"},      locked, 0);
    check({tag, ".pix_valid"},   pix_valid, 0);
    check({tag, ".frame_start"}, frame_start, 0);
    check({tag, ".h_total"},     h_total, 0);
    check({tag, ".v_total"},     v_total, 0);
    check({tag, ".pix_x"},       pix_x, 0);
    check({tag, ".pix_y"},       pix_y, 0);
    check({tag, ".pix_rgb"},     {pix_r, pix_g, pix_b}, 0);
  endtask

  // One pixel tick: inputs presented with pix_en high for one clk, then one idle clk.
  task automatic drive_tick(input logic hs, input logic vs,
                            input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    hs_in = hs; vs_in = vs; r_in = r; g_in = g; b_in = b;
    pix_en = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic hold_ticks(input int n);
    for (int i = 0; i < n; i++) drive_tick(1'b1, 1'b1, 8'd0, 8'd0, 8'd0);
  endtask

  // Gradient: r = 12x, g = 30y, b = ((2r mod 256) + g) >> 1.
  // Examples: (0,0)->0/0/0; (5,3)->60/90/105; (19,7)->228/210/(200+210)>>1=205.
  task automatic run_frame(input int lock_exp, input bit exp_pix,
                           input int bad_line, input int exp_cnt);
    int         start_cnt;
    int         len, x, y;
    logic       act;
    logic [7:0] r, g, b;
    logic [8:0] sum;
    pix_t       p;
    start_cnt = pix_cnt;
    for (int l = 0; l < VT; l++) begin
      len = (l == bad_line) ? HT - 1 : HT;
      for (int c = 0; c < len; c++) begin
        if (l == 1 && c == 0 && lock_exp >= 0) begin
          check("locked_at_frame", locked, lock_exp);
          if (lock_exp == 1) begin
            check("h_total", h_total, HT);
            check("v_total", v_total, VT);
          end
        end
        if (bad_line >= 0 && l == bad_line + 1 && c == S + 3)
          check("locked_after_short_line", locked, 0);
        act = (c >= HS) && (c < HS + HA) && (l >= VS) && (l < VS + VA);
        x = c - HS;
        y = l - VS;
        r = 8'd0; g = 8'd0; b = 8'd0;
        if (act) begin
          r   = 8'(x * 12);
          g   = 8'(y * 30);
          sum = {1'b0, r[6:0], 1'b0} + {1'b0, g};
          b   = sum[8:1];
          if (exp_pix && (bad_line < 0 || l <= bad_line)) begin
            p.x = 10'(x); p.y = 10'(y); p.r = r; p.g = g; p.b = b;
            p.fs = (x == 0 && y == 0);
            exp_q.push_back(p);
          end
        end
        drive_tick((c < HSW) ? 1'b0 : 1'b1, (l < VSW) ? 1'b0 : 1'b1, r, g, b);
      end
    end
    check("pixels_in_frame", pix_cnt - start_cnt, exp_cnt);
  endtask

  initial begin
    pix_t e;
    rst_n = 1'b0; pix_en = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
    r_in = 8'd0; g_in = 8'd0; b_in = 8'd0;

    // Monitor: every pix_valid pulse pops one expected pixel.
    fork
      forever begin
        @(negedge clk);
        if (pix_valid) begin
          pix_cnt++;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_pixel: got x=%0d y=%0d, expected no pixel", pix_x, pix_y);
          end else begin
            e = exp_q.pop_front();
            if ({pix_x, pix_y, pix_r, pix_g, pix_b, frame_start} != e) begin
              n_bad++;
              $display("FAIL pixel: got x=%0d y=%0d rgb=%0d/%0d/%0d fs=%0d, expected x=%0d y=%0d rgb=%0d/%0d/%0d fs=%0d",
                       pix_x, pix_y, pix_r, pix_g, pix_b, frame_start,
                       e.x, e.y, e.r, e.g, e.b, e.fs);
            end
          end
        end else if (frame_start) begin
          n_cmp++;
          n_bad++;
          $display("FAIL frame_start_without_valid: got frame_start=1, expected 0");
        end
      end
    join_none

    repeat (4) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Acquire: measure, confirm, then locked output from the third frame.
    run_frame(0, 1'b0, -1, 0);
    run_frame(0, 1'b0, -1, 0);
    run_frame(1, 1'b1, -1, HA * VA);
    run_frame(1, 1'b1, -1, HA * VA);

    // One short line in active row y=2: pixels up to that line, then unlocked.
    run_frame(1, 1'b1, 5, 3 * HA);
    run_frame(0, 1'b0, -1, 0);
    run_frame(0, 1'b0, -1, 0);
    run_frame(1, 1'b1, -1, HA * VA);

    // Sync loss: still locked before the timeout, SEARCH after, totals held.
    hold_ticks(1900);
    check("locked_before_timeout", locked, 1);
    hold_ticks(200);
    check("locked_after_timeout", locked, 0);
    check("h_total_held", h_total, HT);
    check("v_total_held", v_total, VT);
    run_frame(0, 1'b0, -1, 0);
    run_frame(0, 1'b0, -1, 0);
    run_frame(1, 1'b1, -1, HA * VA);

    // Asynchronous reset in the middle of a line, checked before any clk edge.
    for (int c = 0; c < 16; c++)
      drive_tick((c < HSW) ? 1'b0 : 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    check("locked_before_async_reset", locked, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_frame(0, 1'b0, -1, 0);
    run_frame(0, 1'b0, -1, 0);
    run_frame(1, 1'b1, -1, HA * VA);

    hold_ticks(20);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
